// File: rtl/shiftreg_pkg.sv
// Shared definitions for the SIPO deframer slice.
//   state_e       : deframer FSM encoding (PARITY is always present in the encoding,
//                   reachable only when SHIFTREG_SIPO_PARITY_EN is defined)
//   DEFAULT_WIDTH : default number of data bits per frame
package shiftreg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/shiftreg_out_reg.sv
// One-entry valid/ready holding register with overrun detection.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_word : a completed word is offered this cycle
//   i_ready        : consumer accepts o_dout when o_valid && i_ready
//   i_clr          : synchronous clear of the sticky overrun flag
//   o_dout         : held word, stable while o_valid
//   o_valid        : o_dout holds an unconsumed word
//   o_overrun      : sticky, a completed word was dropped
module shiftreg_out_reg
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;

    logic w_take;
    logic w_store;
    logic w_drop;

    // A word can be stored when the slot is empty or being emptied this cycle.
    assign w_take  = r_valid & i_ready;
    assign w_store = i_load & (~r_valid | i_ready);
    assign w_drop  = i_load & r_valid & ~i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_store) begin
                r_dout <= i_word;
            end
            r_valid   <= w_store | (r_valid & ~w_take);
            // A new drop wins over a simultaneous clear.
            r_overrun <= w_drop | (r_overrun & ~i_clr);
        end
    end

    assign o_dout    = r_dout;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/shiftreg_sipo_deframer.sv
// Serial-in parallel-out deframer: hunts for a start bit (1), shifts in WIDTH data
// bits MSB-first and presents the word on a valid/ready output.
// Optional feature macro: SHIFTREG_SIPO_PARITY_EN adds an even-parity bit after the
// data, the o_parity_err port, and drives o_err = parity_err | overrun.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : sample strobe, i_din only meaningful when high
//   i_din          : serial data from the upstream PISO
//   o_dout         : received word, MSB is the first data bit
//   o_valid        : o_dout holds an unconsumed word
//   i_ready        : consumer accepts o_dout when o_valid && i_ready
//   o_overrun      : sticky, a completed frame was dropped
//   i_clr          : synchronous clear of the sticky flags
//   o_busy         : FSM is not idle
//   o_parity_err   : sticky parity mismatch (parity build only)
//   o_err          : error sink for the TMR voter
module shiftreg_sipo_deframer
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    input  logic             i_clr,
    output logic             o_busy,
`ifdef SHIFTREG_SIPO_PARITY_EN
    output logic             o_parity_err,
`endif
    output logic             o_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;
    logic [WIDTH-1:0] w_word;
    logic             w_overrun;

`ifdef SHIFTREG_SIPO_PARITY_EN
    logic w_par_bad;
    logic r_parity_err;
`else
    // The MSB of the shifter is only read back in the parity build.
    logic w_unused_msb;
    assign w_unused_msb = r_shreg[WIDTH-1];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_word      = r_shreg;
`ifdef SHIFTREG_SIPO_PARITY_EN
        w_par_bad   = 1'b0;
`endif
        if (i_en) begin
            case (r_state)
                IDLE: begin
                    if (i_din) begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], i_din};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
`ifdef SHIFTREG_SIPO_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = IDLE;
                        w_load      = 1'b1;
                        w_word      = w_shreg_nxt;
`endif
                    end
                end
`ifdef SHIFTREG_SIPO_PARITY_EN
                PARITY: begin
                    // Even parity over data plus parity bit must be 0.
                    w_state_nxt = IDLE;
                    w_load      = 1'b1;
                    w_word      = r_shreg;
                    w_par_bad   = (^r_shreg) ^ i_din;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    shiftreg_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_word   (w_word),
        .i_ready  (i_ready),
        .i_clr    (i_clr),
        .o_dout   (o_dout),
        .o_valid  (o_valid),
        .o_overrun(w_overrun)
    );

    assign o_overrun = w_overrun;
    assign o_busy    = (r_state != IDLE);

`ifdef SHIFTREG_SIPO_PARITY_EN
    // Set even if the word itself is dropped for overrun; set wins over clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (w_load & w_par_bad) | (r_parity_err & ~i_clr);
        end
    end

    assign o_parity_err = r_parity_err;
    assign o_err        = r_parity_err | w_overrun;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_shiftreg_sipo_deframer.sv
// Scoreboard bench for shiftreg_sipo_deframer (WIDTH=4): stimulus pushes expected
// words, a negedge monitor pops and compares on every valid && ready handoff.
module tb_shiftreg_sipo_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       din;
    logic [3:0] dout;
    logic       valid;
    logic       ready;
    logic       overrun;
    logic       clr;
    logic       busy;
    logic       err;
`ifdef SHIFTREG_SIPO_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    shiftreg_sipo_deframer #(
        .WIDTH(4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_din       (din),
        .o_dout      (dout),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_overrun   (overrun),
        .i_clr       (clr),
        .o_busy      (busy),
`ifdef SHIFTREG_SIPO_PARITY_EN
        .o_parity_err(parity_err),
`endif
        .o_err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handoff must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL handoff: got word %0h expected none", dout);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL handoff: got word %0h expected %0h", dout, e);
                end
            end
        end
    end

    task automatic tick(input logic e, input logic d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Start bit, 4 data bits MSB first, then parity in the parity build.
    // ready takes ready_last only for the final sample of the frame.
    task automatic send_frame(input logic [3:0] data, input logic bad_par,
                              input logic ready_last);
        tick(1'b1, 1'b1);
`ifdef SHIFTREG_SIPO_PARITY_EN
        for (int i = 3; i >= 0; i--) tick(1'b1, data[i]);
        ready = ready_last;
        tick(1'b1, (^data) ^ bad_par);
`else
        for (int i = 3; i >= 1; i--) tick(1'b1, data[i]);
        ready = ready_last;
        tick(1'b1, data[0]);
        if (bad_par) ready = ready_last;
`endif
    endtask

    task automatic drain();
        ready = 1'b1;
        tick(1'b0, 1'b0);
        ready = 1'b0;
    endtask

    initial begin
        logic [4:0] sparse_bits;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dout", 32'(dout), 32'h0);
        check("reset valid", 32'(valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);
        check("reset err", 32'(err), 32'h0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // Reset mid-frame, then a clean frame.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("midframe busy before reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midframe reset valid", 32'(valid), 32'h0);
        check("midframe reset busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        exp_q.push_back(4'b1010);
        send_frame(4'b1010, 1'b0, 1'b0);
        check("after reset frame valid", 32'(valid), 32'h1);
        check("after reset frame dout", 32'(dout), 32'hA);
        drain();

        // Basic frame: valid one clk after the last sample, drops after ready.
        exp_q.push_back(4'b1011);
        tick(1'b1, 1'b1);
        check("basic busy after start", 32'(busy), 32'h1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
`ifdef SHIFTREG_SIPO_PARITY_EN
        tick(1'b1, 1'b1);
        check("basic valid before parity", 32'(valid), 32'h0);
        tick(1'b1, 1'b1);
`else
        check("basic valid before last bit", 32'(valid), 32'h0);
        tick(1'b1, 1'b1);
`endif
        check("basic valid", 32'(valid), 32'h1);
        check("basic busy after frame", 32'(busy), 32'h0);
        tick(1'b0, 1'b0);
        check("basic valid held", 32'(valid), 32'h1);
        drain();
        check("basic valid dropped", 32'(valid), 32'h0);

        // Sparse en with garbage on din between strobes.
        exp_q.push_back(4'b1011);
`ifdef SHIFTREG_SIPO_PARITY_EN
        sparse_bits = 5'b11011;
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, sparse_bits[i]);
            tick(1'b0, 1'($urandom_range(0, 1)));
            tick(1'b0, 1'($urandom_range(0, 1)));
        end
        tick(1'b1, 1'b1);
`else
        sparse_bits = 5'b11011;
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, sparse_bits[i]);
            if (i != 0) begin
                tick(1'b0, 1'($urandom_range(0, 1)));
                tick(1'b0, 1'($urandom_range(0, 1)));
            end
        end
`endif
        check("sparse valid", 32'(valid), 32'h1);
        check("sparse dout", 32'(dout), 32'hB);
        drain();

        // Overrun: second frame dropped while first still held.
        exp_q.push_back(4'b1010);
        send_frame(4'b1010, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0);
        check("overrun dout held", 32'(dout), 32'hA);
        check("overrun flag", 32'(overrun), 32'h1);
        tick(1'b0, 1'b0);
        check("overrun sticky", 32'(overrun), 32'h1);
`ifndef SHIFTREG_SIPO_PARITY_EN
        check("plain err tied", 32'(err), 32'h0);
`else
        check("parity build err on overrun", 32'(err), 32'h1);
`endif
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        check("overrun cleared", 32'(overrun), 32'h0);
        drain();

        // Handoff and completion in the same cycle: no overrun.
        exp_q.push_back(4'b1010);
        send_frame(4'b1010, 1'b0, 1'b0);
        exp_q.push_back(4'b0110);
        send_frame(4'b0110, 1'b0, 1'b1);
        check("simul valid", 32'(valid), 32'h1);
        check("simul dout", 32'(dout), 32'h6);
        check("simul no overrun", 32'(overrun), 32'h0);
        tick(1'b0, 1'b0);
        ready = 1'b0;
        check("simul valid dropped", 32'(valid), 32'h0);

        // Idle-low noise is ignored.
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            check("idle noise busy", 32'(busy), 32'h0);
            check("idle noise valid", 32'(valid), 32'h0);
        end

`ifdef SHIFTREG_SIPO_PARITY_EN
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0);
        check("parity good dout", 32'(dout), 32'hB);
        check("parity good flag", 32'(parity_err), 32'h0);
        drain();
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1'b1, 1'b0);
        check("parity bad valid", 32'(valid), 32'h1);
        check("parity bad flag", 32'(parity_err), 32'h1);
        check("parity bad err", 32'(err), 32'h1);
        drain();
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        check("parity err cleared", 32'(parity_err), 32'h0);
`endif

        tick(1'b0, 1'b0);
        check("scoreboard empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
